// File: rtl/dma_desc_sched.sv
// dma_desc_sched: walks the DMA descriptor slots in order, hands each enabled
// non-empty descriptor to the read and write streamers, waits for both to
// finish, captures the first reported error and publishes {error, done}.
// Optional build macro: DMA_DESC_CHECK_EN. When defined, a selected
// descriptor whose src/dst address is not BUS_BYTES aligned is refused and
// reported as DMA_UNALIGNED_ERR instead of being dispatched.
module dma_desc_sched #(
    parameter int NUM_DESC  = 2,
    parameter int DESC_W    = 96,
    parameter int BUS_BYTES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dma_go_i,
    input  logic                         dma_abort_i,
    input  logic [NUM_DESC-1:0]          desc_en_i,
    input  logic [NUM_DESC*DESC_W-1:0]   desc_i,
    output logic [DESC_W-1:0]            rd_desc_o,
    output logic                         rd_desc_valid_o,
    input  logic                         rd_desc_ready_i,
    output logic [DESC_W-1:0]            wr_desc_o,
    output logic                         wr_desc_valid_o,
    input  logic                         wr_desc_ready_i,
    input  logic                         rd_done_i,
    input  logic                         wr_done_i,
    input  logic [34:0]                  err_i,
    output logic [34:0]                  err_o,
    output logic [1:0]                   status_o,
    output logic [2:0]                   cur_desc_o,
    output logic                         busy_o
);

    // Error source codes carried in err[2:1].
    localparam logic [1:0] DMA_AXI_RD_ERR    = 2'b01;
    localparam logic [1:0] DMA_AXI_WR_ERR    = 2'b10;
    localparam logic [1:0] DMA_UNALIGNED_ERR = 2'b11;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SCAN     = 3'd1;
    localparam logic [2:0] S_DISPATCH = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    // Elaboration-time sanity checks on the configuration.
    generate
        if (NUM_DESC < 1 || NUM_DESC > 8) begin : g_bad_num_desc
            $error("dma_desc_sched: NUM_DESC must be 1..8");
        end
        if (DESC_W != 96) begin : g_bad_desc_w
            $error("dma_desc_sched: DESC_W must be 96");
        end
        if (BUS_BYTES < 1 || (BUS_BYTES & (BUS_BYTES - 1)) != 0) begin : g_bad_bus_bytes
            $error("dma_desc_sched: BUS_BYTES must be a power of 2");
        end
    endgenerate

    logic [2:0]        r_state;
    logic [2:0]        r_idx;
    logic [DESC_W-1:0] r_rd_desc;
    logic [DESC_W-1:0] r_wr_desc;
    logic              r_rd_valid;
    logic              r_wr_valid;
    logic              r_rd_done;
    logic              r_wr_done;
    logic [34:0]       r_err;
    logic [1:0]        r_status;

    logic [DESC_W-1:0] w_cur_desc;
    logic              w_cur_en;
    logic              w_last;
    logic              w_hs_complete;

    // Select the descriptor and enable bit of the slot under idx.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_cur_desc = '0;
        w_cur_en   = 1'b0;
        for (int k = 0; k < NUM_DESC; k++) begin
            if (r_idx == 3'(k)) begin
                w_cur_desc = desc_i[k*DESC_W +: DESC_W];
                w_cur_en   = desc_en_i[k];
            end
        end
    end

    assign w_last = (r_idx == 3'(NUM_DESC - 1));

    // Both sides are finished with the handshake once each valid is either
    // already low or being accepted this cycle.
    assign w_hs_complete = (!r_rd_valid || rd_desc_ready_i) &&
                           (!r_wr_valid || wr_desc_ready_i);

`ifdef DMA_DESC_CHECK_EN
    localparam logic [31:0] ALIGN_MASK = 32'(BUS_BYTES - 1);

    logic        w_src_unal;
    logic        w_dst_unal;
    logic [31:0] w_bad_addr;

    assign w_src_unal = |(w_cur_desc[95:64] & ALIGN_MASK);
    assign w_dst_unal = |(w_cur_desc[63:32] & ALIGN_MASK);
    // Source address is reported in preference when both are misaligned.
    assign w_bad_addr = w_src_unal ? w_cur_desc[95:64] : w_cur_desc[63:32];
`endif

    // Scheduler FSM, descriptor/valid registers, done flags, error capture and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_rd_desc  <= '0;
            r_wr_desc  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_valid <= 1'b0;
            r_rd_done  <= 1'b0;
            r_wr_done  <= 1'b0;
            r_err      <= '0;
            r_status   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            if (!r_err[0] && err_i[0]) begin
                r_err <= err_i;
            end

            // Done pulses may arrive while the other side is still handshaking.
            if (r_state == S_DISPATCH || r_state == S_WAIT) begin
                if (rd_done_i) r_rd_done <= 1'b1;
                if (wr_done_i) r_wr_done <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_state == S_DONE && !r_status[0]) begin
                        r_status <= {r_err[0], 1'b1};
                    end
                    if (dma_go_i) begin
                        r_idx     <= '0;
                        r_status  <= '0;
                        r_err     <= '0;
                        r_rd_done <= 1'b0;
                        r_wr_done <= 1'b0;
                        r_state   <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (dma_abort_i || r_err[0]) begin
                        r_state <= S_DONE;
                    end else if (w_cur_en && w_cur_desc[31:0] != 32'd0) begin
`ifdef DMA_DESC_CHECK_EN
                        if (w_src_unal || w_dst_unal) begin
                            r_err   <= {w_bad_addr, DMA_UNALIGNED_ERR, 1'b1};
                            r_state <= S_DONE;
                        end else
`endif
                        begin
                            r_rd_desc  <= w_cur_desc;
                            r_wr_desc  <= w_cur_desc;
                            r_rd_valid <= 1'b1;
                            r_wr_valid <= 1'b1;
                            r_state    <= S_DISPATCH;
                        end
                    end else if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end

                S_DISPATCH: begin
                    if (r_rd_valid && rd_desc_ready_i) r_rd_valid <= 1'b0;
                    if (r_wr_valid && wr_desc_ready_i) r_wr_valid <= 1'b0;
                    if (w_hs_complete) r_state <= S_WAIT;
                end

                S_WAIT: begin
                    if (r_rd_done && r_wr_done) begin
                        r_rd_done <= 1'b0;
                        r_wr_done <= 1'b0;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= S_SCAN;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_desc_o       = r_rd_desc;
    assign wr_desc_o       = r_wr_desc;
    assign rd_desc_valid_o = r_rd_valid;
    assign wr_desc_valid_o = r_wr_valid;
    assign err_o           = r_err;
    assign status_o        = r_status;
    assign cur_desc_o      = r_idx;
    assign busy_o          = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: doc/dma_desc_sched.md
Name: dma_desc_sched

Overview:
Descriptor scheduler that sequences the DMA descriptor slots into the read and write streamers. On a go pulse it walks slots 0..NUM_DESC-1 in order and skips disabled or zero-length slots. For each remaining slot it hands the same descriptor to both streamers, waits for both done pulses, then advances. It aggregates errors and produces the {error, done} status word consumed by the DMA CSR block.

Parameters:
NUM_DESC, 2, number of descriptor slots (DMA_NUM_DESC); 1..8
DESC_W, 96, packed descriptor width: src_addr[95:64], dst_addr[63:32], num_bytes[31:0]
BUS_BYTES, 8, AXI data bus width in bytes; power of 2; used only by the optional feature

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
dma_go_i  in  1  start pulse; ignored unless state is IDLE or DONE
dma_abort_i  in  1  level; no new dispatch while high
desc_en_i  in  NUM_DESC  per-slot enable
desc_i  in  NUM_DESC*DESC_W  descriptor array; slot k at [k*DESC_W +: DESC_W]
rd_desc_o  out  DESC_W  descriptor to read streamer
rd_desc_valid_o  out  1  valid/ready handshake to read streamer
rd_desc_ready_i  in  1  read streamer accepts
wr_desc_o  out  DESC_W  descriptor to write streamer
wr_desc_valid_o  out  1  valid/ready handshake to write streamer
wr_desc_ready_i  in  1  write streamer accepts
rd_done_i  in  1  one-cycle pulse: read side finished current descriptor
wr_done_i  in  1  one-cycle pulse: write side finished current descriptor
err_i  in  35  error report {addr[34:3], src[2:1], valid[0]}
err_o  out  35  first error captured; cleared on go
status_o  out  2  {error, done}
cur_desc_o  out  3  index of the slot in flight
busy_o  out  1  state is neither IDLE nor DONE

Behaviour:
- Reset values: all outputs 0; state IDLE; idx 0.
- States: IDLE, SCAN, DISPATCH, WAIT, DONE.
- IDLE/DONE + go:
  - idx<=0, status_o<=0, err_o<=0.
  - Go to SCAN.
- SCAN, one slot per cycle:
  - If abort=1 or err_o.valid=1: go to DONE.
  - Else if desc_en_i[idx]=1 and num_bytes!=0: latch the descriptor into rd_desc_o and wr_desc_o, set both valids, go to DISPATCH.
  - Else if idx==NUM_DESC-1: go to DONE.
  - Else idx++.
- DISPATCH:
  - Each valid drops in the cycle after its own valid&ready. The two sides are independent and may complete in either order or the same cycle.
  - Descriptor outputs stay stable while their valid is high.
  - When both have handshaken, go to WAIT.
  - rd_done_i/wr_done_i are latched in sticky flags even if they arrive during DISPATCH.
- WAIT, when both sticky done flags are set:
  - Clear the flags.
  - If idx==NUM_DESC-1: go to DONE.
  - Else idx++ and go to SCAN.
- DONE:
  - Entry cycle: status_o.done<=1, status_o.error<=err_o.valid. Both hold until the next go.
  - A go pulse in DONE restarts directly.
- Errors:
  - First err_i with valid=1 is captured into err_o; later errors are ignored.
  - In DISPATCH/WAIT, an error does not abort the in-flight descriptor; the FSM finishes the handshakes and done waits, then SCAN exits to DONE.
- Abort (raised mid-descriptor):
  - The in-flight descriptor is completed; no further slot is dispatched.
  - status_o.done=1, error unaffected.
- go while busy: ignored.
- desc_i/desc_en_i changes: sampled only in SCAN for the current idx; later slots may be reprogrammed while busy.
- Latency: go to first valid is at least 2 cycles (SCAN, then valid registered). Each skipped slot costs 1 cycle.
- cur_desc_o = idx, zero-extended.

Optional Feature:
DMA_DESC_CHECK_EN
- Defined: in SCAN, a selected slot with src_addr or dst_addr not a multiple of BUS_BYTES is not dispatched.
  - err_o <= {offending addr (src checked first), DMA_UNALIGNED_ERR, 1}, if err_o is empty.
  - FSM goes to DONE with status_o=2'b11.
- Undefined: no check; unaligned descriptors are dispatched unchanged.

Test Plan:
- Both slots enabled, lengths 0x40/0x80, ready=1, done pulses 10 cycles after dispatch -> two dispatches, slot 0 then 1, with cur_desc_o=0 then 1 -> status_o=2'b01, err_o=0.
- desc_en_i=2'b10 and slot1 num_bytes=0 -> no valid ever asserted; DONE reached 3 cycles after go; status_o=2'b01.
- wr_ready held low 5 cycles while rd_ready=1; wr_done_i pulses before rd_done_i -> rd valid drops first, wr_desc_o stays stable, advance only after both dones.
- err_i={0x1000,DMA_AXI_RD_ERR,1} during slot 0 WAIT -> slot 0 completes, slot 1 not dispatched, err_o.addr=0x1000, status_o=2'b11.
- Abort asserted during slot 0 DISPATCH -> slot 0 completes, status_o=2'b01; go during busy ignored; go in DONE restarts and clears status.
- With DMA_DESC_CHECK_EN: slot 0 src_addr=0x1004, BUS_BYTES=8 -> no valid; err_o={0x1004,DMA_UNALIGNED_ERR,1}; status_o=2'b11. Async rst mid-WAIT -> all outputs 0 immediately.
